// File: rtl/mm2s_read_scheduler.sv
// mm2s_read_scheduler: splits per-channel read regions into burst commands
// that never cross a BURST_BYTES boundary, round-robins enabled channels onto
// one command port and replays the whole region set repeat_cnt times.
// Optional build macro: MM2S_SCHED_ABORT_EN adds an abort input that ends the
// run early once any command already presented has been accepted.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// IDLE     | waiting for mm2s_start, core_ready high
// LOAD     | snapshot inputs, present first command or finish if nothing to do
// ISSUE    | present / hold burst commands until every region is drained
// PASS_END | count down passes, reload regions and present the next pass
// DONE     | run finished, done pulses on the following cycle
module mm2s_read_scheduler #(
  parameter  int ADDR_WIDTH  = 64,
  parameter  int N_CHANNELS  = 16,
  parameter  int BURST_BYTES = 4096,
  localparam int CH_W        = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
  localparam int BYTES_W     = $clog2(BURST_BYTES) + 1
) (
  input  logic                             mem_clk,
  input  logic                             mem_rst,
  input  logic                             mm2s_start,
  input  logic [N_CHANNELS-1:0]            channel_en,
  input  logic [N_CHANNELS*ADDR_WIDTH-1:0] rd_addr,
  input  logic [N_CHANNELS*ADDR_WIDTH-1:0] rd_size,
  input  logic [31:0]                      repeat_cnt,
  output logic                             core_ready,
  output logic                             cmd_valid,
  input  logic                             cmd_ready,
`ifdef MM2S_SCHED_ABORT_EN
  input  logic                             abort,
`endif
  output logic [ADDR_WIDTH-1:0]            cmd_addr,
  output logic [BYTES_W-1:0]               cmd_bytes,
  output logic [CH_W-1:0]                  cmd_chan,
  output logic                             cmd_last,
  output logic                             done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_PASS_END,
    S_DONE
  } state_t;

  state_t state, next_state;

  logic [ADDR_WIDTH-1:0] snap_base [N_CHANNELS];
  logic [ADDR_WIDTH-1:0] snap_size [N_CHANNELS];
  logic [ADDR_WIDTH-1:0] cur_addr  [N_CHANNELS];
  logic [ADDR_WIDTH-1:0] remaining [N_CHANNELS];
  logic [N_CHANNELS-1:0] snap_act;

  // view_* is what the grant search looks at: live inputs in LOAD, the
  // snapshot in PASS_END (so the next pass's first command can be presented
  // on the same edge as the reload), and the working registers otherwise.
  logic [ADDR_WIDTH-1:0] view_addr [N_CHANNELS];
  logic [ADDR_WIDTH-1:0] view_rem  [N_CHANNELS];
  logic [N_CHANNELS-1:0] view_act;

  logic [31:0]           pass_left;
  logic [CH_W-1:0]       rr_ptr;
  logic                  done_q;

  logic [CH_W-1:0]       grant;
  logic                  grant_found;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [ADDR_WIDTH-1:0] g_rem;
  logic [ADDR_WIDTH-1:0] g_off;
  logic [ADDR_WIDTH-1:0] g_room;
  logic                  g_last;
  logic [BYTES_W-1:0]    g_bytes;

  logic                  hs;
  logic                  load_cmd;
  logic                  abort_any;

  assign hs         = cmd_valid && cmd_ready;
  assign done       = done_q;
  // done_q blocks a new start during the done pulse so core_ready rises after it
  assign core_ready = (state == S_IDLE) && !done_q;

`ifdef MM2S_SCHED_ABORT_EN
  logic abort_q;

  // Remember an abort seen while a command was pending until that command retires
  always_ff @(posedge mem_clk) begin
    if (mem_rst) begin
      abort_q <= 1'b0;
    end else if (state == S_IDLE) begin
      abort_q <= 1'b0;
    end else if (state == S_ISSUE && abort) begin
      abort_q <= 1'b1;
    end
  end

  assign abort_any = (state == S_ISSUE) && (abort || abort_q);
`else
  assign abort_any = 1'b0;
`endif

  // Select the per-channel region view the grant search operates on
  always_comb begin
    view_act = '0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      case (state)
        S_LOAD: begin
          view_addr[i] = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          view_rem[i]  = rd_size[i*ADDR_WIDTH +: ADDR_WIDTH];
          view_act[i]  = channel_en[i] && (rd_size[i*ADDR_WIDTH +: ADDR_WIDTH] != '0);
        end
        S_PASS_END: begin
          view_addr[i] = snap_base[i];
          view_rem[i]  = snap_size[i];
          view_act[i]  = snap_act[i];
        end
        default: begin
          view_addr[i] = cur_addr[i];
          view_rem[i]  = remaining[i];
          view_act[i]  = snap_act[i];
        end
      endcase
    end
  end

  // Round-robin search: first active channel with bytes left, from rr_ptr upward
  always_comb begin : grant_search
    logic [CH_W:0]   idx_w;
    logic [CH_W-1:0] idx;
    grant       = '0;
    grant_found = 1'b0;
    idx_w       = '0;
    idx         = '0;
    for (int k = 0; k < N_CHANNELS; k++) begin
      idx_w = {1'b0, rr_ptr} + (CH_W+1)'(k);
      if (idx_w >= (CH_W+1)'(N_CHANNELS)) begin
        idx_w = idx_w - (CH_W+1)'(N_CHANNELS);
      end
      idx = idx_w[CH_W-1:0];
      if (!grant_found && view_act[idx] && (view_rem[idx] != '0)) begin
        grant_found = 1'b1;
        grant       = idx;
      end
    end
  end

  // Burst size for the granted channel, clipped at the next burst boundary
  always_comb begin
    g_addr  = view_addr[grant];
    g_rem   = view_rem[grant];
    g_off   = g_addr & ADDR_WIDTH'(BURST_BYTES - 1);
    g_room  = ADDR_WIDTH'(BURST_BYTES) - g_off;
    g_last  = (g_rem <= g_room);
    g_bytes = g_last ? g_rem[BYTES_W-1:0] : g_room[BYTES_W-1:0];
  end

  // State register
  always_ff @(posedge mem_clk) begin
    if (mem_rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and command-load strobe
  always_comb begin
    next_state = state;
    load_cmd   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (mm2s_start && !done_q) begin
          next_state = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!grant_found || (repeat_cnt == '0)) begin
          next_state = S_DONE;
        end else begin
          load_cmd   = 1'b1;
          next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cmd_valid) begin
          // a presented command is never withdrawn; abort waits for its handshake
          if (hs && abort_any) begin
            next_state = S_DONE;
          end
        end else if (abort_any) begin
          next_state = S_DONE;
        end else if (grant_found) begin
          load_cmd = 1'b1;
        end else begin
          next_state = S_PASS_END;
        end
      end
      S_PASS_END: begin
        if ((pass_left == 32'd1) || !grant_found) begin
          next_state = S_DONE;
        end else begin
          load_cmd   = 1'b1;
          next_state = S_ISSUE;
        end
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Command outputs, pass down-counter, round-robin pointer and done pulse
  always_ff @(posedge mem_clk) begin
    if (mem_rst) begin
      cmd_valid <= 1'b0;
      cmd_addr  <= '0;
      cmd_bytes <= '0;
      cmd_chan  <= '0;
      cmd_last  <= 1'b0;
      done_q    <= 1'b0;
      rr_ptr    <= '0;
      pass_left <= '0;
      snap_act  <= '0;
    end else begin
      done_q <= (state == S_DONE);
      if (state == S_LOAD) begin
        snap_act  <= view_act;
        pass_left <= repeat_cnt;
      end
      if (state == S_PASS_END) begin
        pass_left <= pass_left - 32'd1;
      end
      if (hs) begin
        cmd_valid <= 1'b0;
        rr_ptr    <= (cmd_chan == CH_W'(N_CHANNELS - 1)) ? '0 : cmd_chan + 1'b1;
      end
      if (load_cmd) begin
        cmd_valid <= 1'b1;
        cmd_addr  <= g_addr;
        cmd_bytes <= g_bytes;
        cmd_chan  <= grant;
        cmd_last  <= g_last;
      end
    end
  end

  // Region snapshot and per-channel progress; always rewritten in LOAD, so no reset
  always_ff @(posedge mem_clk) begin
    for (int i = 0; i < N_CHANNELS; i++) begin
      if (state == S_LOAD) begin
        snap_base[i] <= view_addr[i];
        snap_size[i] <= view_rem[i];
        cur_addr[i]  <= view_addr[i];
        remaining[i] <= view_rem[i];
      end else if (state == S_PASS_END) begin
        cur_addr[i]  <= snap_base[i];
        remaining[i] <= snap_size[i];
      end else if (hs && (cmd_chan == CH_W'(i))) begin
        cur_addr[i]  <= cur_addr[i] + ADDR_WIDTH'(cmd_bytes);
        remaining[i] <= remaining[i] - ADDR_WIDTH'(cmd_bytes);
      end
    end
  end

endmodule

// File: tb/tb_mm2s_read_scheduler.sv
// tb_mm2s_read_scheduler: directed vectors for mm2s_read_scheduler with
// hand-computed burst commands plus hand-written multi-cycle sequences.
module tb_mm2s_read_scheduler;
  localparam int AW      = 64;
  localparam int NC      = 16;
  localparam int BB      = 4096;
  localparam int CH_W    = 4;
  localparam int BYTES_W = 13;

  logic                 mem_clk = 1'b0;
  logic                 mem_rst;
  logic                 mm2s_start;
  logic [NC-1:0]        channel_en;
  logic [NC*AW-1:0]     rd_addr;
  logic [NC*AW-1:0]     rd_size;
  logic [31:0]          repeat_cnt;
  logic                 core_ready;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [AW-1:0]        cmd_addr;
  logic [BYTES_W-1:0]   cmd_bytes;
  logic [CH_W-1:0]      cmd_chan;
  logic                 cmd_last;
  logic                 done;
`ifdef MM2S_SCHED_ABORT_EN
  logic                 abort;
`endif

  mm2s_read_scheduler #(.ADDR_WIDTH(AW), .N_CHANNELS(NC), .BURST_BYTES(BB)) dut (
    .mem_clk    (mem_clk),
    .mem_rst    (mem_rst),
    .mm2s_start (mm2s_start),
    .channel_en (channel_en),
    .rd_addr    (rd_addr),
    .rd_size    (rd_size),
    .repeat_cnt (repeat_cnt),
    .core_ready (core_ready),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
`ifdef MM2S_SCHED_ABORT_EN
    .abort      (abort),
`endif
    .cmd_addr   (cmd_addr),
    .cmd_bytes  (cmd_bytes),
    .cmd_chan   (cmd_chan),
    .cmd_last   (cmd_last),
    .done       (done)
  );

  always #5 mem_clk = ~mem_clk;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  // count done pulses; read at posedge so the test thread at negedge never races it
  always @(posedge mem_clk) begin
    if (done === 1'b1) done_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          sc;
    logic [63:0] addr;
    int          bytes;
    int          chan;
    bit          last;
    int          stall;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_ch(input int i, input logic [63:0] a, input logic [63:0] s, input bit en);
    rd_addr[i*AW +: AW] = a;
    rd_size[i*AW +: AW] = s;
    channel_en[i]       = en;
  endtask

  task automatic clear_cfg();
    rd_addr    = '0;
    rd_size    = '0;
    channel_en = '0;
    repeat_cnt = 32'd1;
  endtask

  // leaves the bench at the negedge of the LOAD cycle
  task automatic start_pulse();
    mm2s_start = 1'b1;
    @(negedge mem_clk);
    mm2s_start = 1'b0;
  endtask

  task automatic expect_cmd(input vec_t v, input string nm);
    int n;
    n = 0;
    while (cmd_valid !== 1'b1 && n < 40) begin
      @(negedge mem_clk);
      n++;
    end
    chk({nm, "_valid"}, 64'(cmd_valid), 64'd1);
    chk({nm, "_addr"},  cmd_addr, v.addr);
    chk({nm, "_bytes"}, 64'(cmd_bytes), 64'(v.bytes));
    chk({nm, "_chan"},  64'(cmd_chan), 64'(v.chan));
    chk({nm, "_last"},  64'(cmd_last), 64'(v.last));
    for (int s = 0; s < v.stall; s++) begin
      @(negedge mem_clk);
      chk({nm, "_hold_valid"}, 64'(cmd_valid), 64'd1);
      chk({nm, "_hold_addr"},  cmd_addr, v.addr);
      chk({nm, "_hold_bytes"}, 64'(cmd_bytes), 64'(v.bytes));
    end
    cmd_ready = 1'b1;
    @(negedge mem_clk);
    cmd_ready = 1'b0;
    chk({nm, "_drop"}, 64'(cmd_valid), 64'd0);
  endtask

  task automatic run_sc(input int sc, input int base, input string nm);
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].sc == sc) begin
        chk({nm, "_early_done"}, 64'(done_cnt), 64'(base));
        expect_cmd(vecs[i], $sformatf("%s_v%0d", nm, i));
      end
    end
  endtask

  task automatic wait_done(input int base, input string nm);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(negedge mem_clk);
      n++;
    end
    chk({nm, "_done"}, 64'(done), 64'd1);
    @(negedge mem_clk);
    chk({nm, "_done_cnt"}, 64'(done_cnt), 64'(base + 1));
    chk({nm, "_ready"}, 64'(core_ready), 64'd1);
    repeat (3) @(negedge mem_clk);
    chk({nm, "_quiet"}, 64'(cmd_valid), 64'd0);
    chk({nm, "_one_done"}, 64'(done_cnt), 64'(base + 1));
  endtask

  task automatic degenerate(input string nm);
    int base;
    base = done_cnt;
    start_pulse();
    chk({nm, "_c1_ready"}, 64'(core_ready), 64'd0);
    @(negedge mem_clk);
    chk({nm, "_c2_valid"}, 64'(cmd_valid), 64'd0);
    chk({nm, "_c2_done"},  64'(done), 64'd0);
    @(negedge mem_clk);
    chk({nm, "_c3_done"},  64'(done), 64'd1);
    chk({nm, "_c3_valid"}, 64'(cmd_valid), 64'd0);
    @(negedge mem_clk);
    chk({nm, "_c4_done"},  64'(done), 64'd0);
    chk({nm, "_c4_ready"}, 64'(core_ready), 64'd1);
    chk({nm, "_c4_cnt"},   64'(done_cnt), 64'(base + 1));
  endtask

  initial begin : main
    int   base;
    vec_t v;

    vecs[0]  = '{1, 64'h1000,  4096, 0, 1'b0, 0};
    vecs[1]  = '{1, 64'h2000,  4096, 0, 1'b0, 0};
    vecs[2]  = '{1, 64'h3000,  2048, 0, 1'b1, 0};
    vecs[3]  = '{2, 64'h0F00,  256,  3, 1'b0, 0};
    vecs[4]  = '{2, 64'h1000,  512,  3, 1'b1, 0};
    vecs[5]  = '{3, 64'h0,     4096, 0, 1'b0, 0};
    vecs[6]  = '{3, 64'h10000, 4096, 2, 1'b0, 0};
    vecs[7]  = '{3, 64'h1000,  4096, 0, 1'b1, 0};
    vecs[8]  = '{3, 64'h11000, 4096, 2, 1'b1, 0};
    vecs[9]  = '{4, 64'h0,     4096, 0, 1'b1, 5};
    vecs[10] = '{4, 64'h0,     4096, 0, 1'b1, 5};
    vecs[11] = '{4, 64'h0,     4096, 0, 1'b1, 5};
    vecs[12] = '{7, 64'h100,   256,  0, 1'b1, 0};
    vecs[13] = '{7, 64'h2000,  16,   1, 1'b1, 0};

    mem_rst    = 1'b1;
    mm2s_start = 1'b0;
    cmd_ready  = 1'b0;
`ifdef MM2S_SCHED_ABORT_EN
    abort      = 1'b0;
`endif
    clear_cfg();
    repeat (3) @(negedge mem_clk);
    chk("rst_core_ready", 64'(core_ready), 64'd1);
    chk("rst_cmd_valid",  64'(cmd_valid), 64'd0);
    chk("rst_cmd_addr",   cmd_addr, 64'd0);
    chk("rst_cmd_bytes",  64'(cmd_bytes), 64'd0);
    chk("rst_cmd_chan",   64'(cmd_chan), 64'd0);
    chk("rst_cmd_last",   64'(cmd_last), 64'd0);
    chk("rst_done",       64'(done), 64'd0);
    mem_rst = 1'b0;
    @(negedge mem_clk);

    // aligned split; inputs scrambled and start re-pulsed while busy
    clear_cfg();
    set_ch(0, 64'h1000, 64'h2800, 1'b1);
    base = done_cnt;
    start_pulse();
    chk("s1_c1_ready", 64'(core_ready), 64'd0);
    chk("s1_c1_valid", 64'(cmd_valid), 64'd0);
    @(negedge mem_clk);
    chk("s1_c2_valid", 64'(cmd_valid), 64'd1);
    set_ch(0, 64'hDEAD000, 64'h40, 1'b1);
    set_ch(5, 64'h8000, 64'h1000, 1'b1);
    repeat_cnt = 32'd7;
    start_pulse();
    run_sc(1, base, "s1");
    wait_done(base, "s1");

    // unaligned split; cmd_ready high while nothing is valid
    clear_cfg();
    set_ch(3, 64'h0F00, 64'h300, 1'b1);
    cmd_ready = 1'b1;
    repeat (3) @(negedge mem_clk);
    chk("s2_idle_ready_ignored", 64'(cmd_valid), 64'd0);
    cmd_ready = 1'b0;
    base = done_cnt;
    start_pulse();
    run_sc(2, base, "s2");
    wait_done(base, "s2");

    // round-robin with an enabled zero-size channel
    clear_cfg();
    set_ch(0, 64'h0,     64'h2000, 1'b1);
    set_ch(1, 64'h4000,  64'h0,    1'b1);
    set_ch(2, 64'h10000, 64'h2000, 1'b1);
    base = done_cnt;
    start_pulse();
    run_sc(3, base, "s3");
    wait_done(base, "s3");

    // three passes under back-pressure
    clear_cfg();
    set_ch(0, 64'h0, 64'h1000, 1'b1);
    repeat_cnt = 32'd3;
    base = done_cnt;
    start_pulse();
    run_sc(4, base, "s4");
    wait_done(base, "s4");

    // degenerate starts
    clear_cfg();
    set_ch(0, 64'h0, 64'h100, 1'b1);
    repeat_cnt = 32'd0;
    degenerate("s5_rep0");
    clear_cfg();
    set_ch(0, 64'h0, 64'h100, 1'b0);
    set_ch(4, 64'h0, 64'h100, 1'b0);
    repeat_cnt = 32'd2;
    degenerate("s5_noen");

    // reset while a command is stalled
    clear_cfg();
    set_ch(2, 64'h5000, 64'h40, 1'b1);
    base = done_cnt;
    start_pulse();
    @(negedge mem_clk);
    chk("s6_valid", 64'(cmd_valid), 64'd1);
    chk("s6_addr",  cmd_addr, 64'h5000);
    chk("s6_bytes", 64'(cmd_bytes), 64'd64);
    chk("s6_chan",  64'(cmd_chan), 64'd2);
    chk("s6_last",  64'(cmd_last), 64'd1);
    @(negedge mem_clk);
    mem_rst = 1'b1;
    @(negedge mem_clk);
    chk("s6_rst_valid", 64'(cmd_valid), 64'd0);
    chk("s6_rst_ready", 64'(core_ready), 64'd1);
    mem_rst = 1'b0;
    repeat (4) @(negedge mem_clk);
    chk("s6_no_done", 64'(done_cnt), 64'(base));

    // fresh run after reset starts from round-robin pointer 0
    clear_cfg();
    set_ch(0, 64'h100,  64'h100, 1'b1);
    set_ch(1, 64'h2000, 64'h10,  1'b1);
    base = done_cnt;
    start_pulse();
    run_sc(7, base, "s7");
    wait_done(base, "s7");

`ifdef MM2S_SCHED_ABORT_EN
    // abort during a stall: held command completes, then done, nothing more
    clear_cfg();
    set_ch(0, 64'h0, 64'h3000, 1'b1);
    repeat_cnt = 32'd2;
    base = done_cnt;
    start_pulse();
    @(negedge mem_clk);
    abort = 1'b1;
    @(negedge mem_clk);
    abort = 1'b0;
    v = '{8, 64'h0, 4096, 0, 1'b0, 2};
    expect_cmd(v, "s8");
    wait_done(base, "s8");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
